// File: rtl/bram_reader_pkg.sv
// Shared types and sizing for the BRAM stream reader.
package bram_reader_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  // One slot per in-flight read plus two, so a full pipe never stalls a steady stream.
  function automatic int fifo_depth(input int read_latency);
    return read_latency + 2;
  endfunction
endpackage

// File: rtl/bram_stream_reader_if.sv
// Request, BRAM port and output stream signals of the BRAM stream reader.
interface bram_stream_reader_if #(
  parameter int RAM_WIDTH = 18,
  parameter int RAM_DEPTH = 1024
);
  localparam int AW = $clog2(RAM_DEPTH);

  logic                 start_in;
  logic [AW-1:0]        base_addr_in;
  logic [AW:0]          len_in;
  logic                 busy_out;
  logic                 done_out;
  logic [AW-1:0]        bram_addr_out;
  logic                 bram_en_out;
  logic                 bram_regce_out;
  logic [RAM_WIDTH-1:0] bram_dout_in;
  logic [RAM_WIDTH-1:0] data_out;
  logic                 valid_out;
  logic                 ready_in;
  logic                 last_out;

  modport slave (
    input  start_in, base_addr_in, len_in, bram_dout_in, ready_in,
    output busy_out, done_out, bram_addr_out, bram_en_out, bram_regce_out,
           data_out, valid_out, last_out
  );

  modport master (
    output start_in, base_addr_in, len_in, bram_dout_in, ready_in,
    input  busy_out, done_out, bram_addr_out, bram_en_out, bram_regce_out,
           data_out, valid_out, last_out
  );
endinterface

// File: rtl/stream_fifo.sv
// Synchronous show-ahead FIFO; head reads as zero while empty.
module stream_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr, r_rd;
  logic [CNT_W-1:0] r_count;
  logic             w_push, w_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_pop  = i_pop && (r_count != '0);
  assign w_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_pop);

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= ptr_inc(r_wr);
      if (w_pop)  r_rd <= ptr_inc(r_rd);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_empty = (r_count == '0);
  assign o_data  = o_empty ? '0 : r_mem[r_rd];
  assign o_count = r_count;
endmodule

// File: rtl/bram_stream_reader.sv
// Walks len BRAM addresses from base, one read per cycle under FIFO credit,
// and returns the words on a valid/ready stream tagged with last.
module bram_stream_reader
  import bram_reader_pkg::*;
#(
  parameter int RAM_WIDTH    = 18,
  parameter int RAM_DEPTH    = 1024,
  parameter int READ_LATENCY = 2
) (
  input logic                clk_in,
  input logic                rst_in,
  bram_stream_reader_if.slave bus
);
  localparam int AW = $clog2(RAM_DEPTH);
  localparam int FD = fifo_depth(READ_LATENCY);
  localparam int CW = $clog2(FD + 1) + 1;

  state_t                  r_state;
  logic [AW-1:0]           r_addr;
  logic [AW:0]             r_remaining;
  logic                    r_en, r_last, r_done;
  logic [READ_LATENCY-1:0] r_vld_pipe, r_last_pipe;

  logic                    w_push, w_pop, w_empty, w_credit, w_issue;
  logic [RAM_WIDTH:0]      w_head;
  logic [CW-1:0]           w_count, w_pipe_cnt, w_pending;
  logic [AW-1:0]           w_addr_nxt;

  // Reads already committed (pipe, current issue, FIFO) as they will stand next cycle.
  always_comb begin
    w_pipe_cnt = '0;
    for (int i = 0; i < READ_LATENCY; i++) w_pipe_cnt = w_pipe_cnt + CW'(r_vld_pipe[i]);
    w_pending = w_pipe_cnt + w_count + CW'(r_en) - CW'(w_pop);
  end

  assign w_credit   = (w_pending < CW'(FD));
  assign w_issue    = (r_state == RUN) && (r_remaining != '0) && w_credit;
  assign w_push     = r_vld_pipe[READ_LATENCY-1];
  assign w_pop      = !w_empty && bus.ready_in;
  assign w_addr_nxt = (r_addr == AW'(RAM_DEPTH - 1)) ? '0 : r_addr + 1'b1;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_en        <= 1'b0;
      r_last      <= 1'b0;
      r_done      <= 1'b0;
      r_vld_pipe  <= '0;
      r_last_pipe <= '0;
    end else begin
      r_vld_pipe[0]  <= r_en;
      r_last_pipe[0] <= r_en && r_last;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_vld_pipe[i]  <= r_vld_pipe[i-1];
        r_last_pipe[i] <= r_last_pipe[i-1];
      end
      r_en   <= 1'b0;
      r_last <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (bus.start_in) begin
          if (bus.len_in == '0) begin
            r_state <= DONE;
          end else begin
            r_en        <= 1'b1;
            r_addr      <= bus.base_addr_in;
            r_remaining <= bus.len_in - (AW+1)'(1);
            r_last      <= (bus.len_in == (AW+1)'(1));
            r_state     <= (bus.len_in == (AW+1)'(1)) ? DRAIN : RUN;
          end
        end
        RUN: if (w_issue) begin
          r_en        <= 1'b1;
          r_addr      <= w_addr_nxt;
          r_remaining <= r_remaining - (AW+1)'(1);
          if (r_remaining == (AW+1)'(1)) begin
            r_last  <= 1'b1;
            r_state <= DRAIN;
          end
        end
        DRAIN: if (w_pop && w_head[RAM_WIDTH]) begin
          r_state <= DONE;
          r_done  <= 1'b1;
        end
        // Empty requests arrive here with done low and spend one extra cycle raising it.
        DONE: begin
          if (r_done) r_state <= IDLE;
          else        r_done  <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  stream_fifo #(
    .WIDTH (RAM_WIDTH + 1),
    .DEPTH (FD),
    .CNT_W (CW)
  ) u_fifo (
    .i_clk   (clk_in),
    .i_rst   (rst_in),
    .i_push  (w_push),
    .i_data  ({r_last_pipe[READ_LATENCY-1], bus.bram_dout_in}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign bus.busy_out       = (r_state != IDLE);
  assign bus.done_out       = r_done;
  assign bus.bram_addr_out  = r_addr;
  assign bus.bram_en_out    = r_en;
  assign bus.bram_regce_out = 1'b1;
  assign bus.data_out       = w_head[RAM_WIDTH-1:0];
  assign bus.valid_out      = !w_empty;
  assign bus.last_out       = w_head[RAM_WIDTH];
endmodule

// File: tb/tb_bram_stream_reader.sv
// Bench for bram_stream_reader: latency-2 BRAM model holding mem[i]=i, expected-beat queue.
module tb_bram_stream_reader;
  localparam int RW = 18;
  localparam int RD = 1024;
  localparam int RL = 2;

  logic clk, rst;
  bram_stream_reader_if #(.RAM_WIDTH(RW), .RAM_DEPTH(RD)) bus();

  bram_stream_reader #(.RAM_WIDTH(RW), .RAM_DEPTH(RD), .READ_LATENCY(RL)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM model: address register gated by en, output register by regce.
  logic [RW-1:0] bq1, bq2;
  always @(posedge clk) begin
    if (bus.bram_en_out) bq1 <= RW'(bus.bram_addr_out);
    if (bus.bram_regce_out) bq2 <= bq1;
  end
  assign bus.bram_dout_in = bq2;

  int n_tests = 0;
  int n_fail  = 0;
  logic [RW:0] q_exp[$];
  logic [9:0]  exp_addr;

  // Stream monitor: expected beats, address sequence, credit limit, stall stability.
  bit          h1, h2, prev_stall;
  int          occ;
  logic [RW:0] prev_beat, got, e;
  always @(negedge clk) begin
    if (rst) begin
      h1 = 0; h2 = 0; occ = 0; prev_stall = 0;
    end else begin
      got = {bus.last_out, bus.data_out};
      if (bus.bram_en_out) begin
        n_tests++;
        if (int'(h1) + int'(h2) + occ > 3) begin
          n_fail++; $display("FAIL credit: read issued with inflight+count=%0d, required <=3", int'(h1) + int'(h2) + occ);
        end
        n_tests++;
        if (bus.bram_addr_out !== exp_addr) begin
          n_fail++; $display("FAIL bram_addr: got %0d expected %0d", bus.bram_addr_out, exp_addr);
        end
        exp_addr = exp_addr + 10'd1;
      end
      n_tests++;
      if (bus.valid_out !== (occ != 0)) begin
        n_fail++; $display("FAIL valid_out: got %0b expected %0b (occupancy %0d)", bus.valid_out, occ != 0, occ);
      end
      if (prev_stall) begin
        n_tests++;
        if (!bus.valid_out || got !== prev_beat) begin
          n_fail++; $display("FAIL stall_stable: got v=%0b beat=%h expected v=1 beat=%h", bus.valid_out, got, prev_beat);
        end
      end
      if (bus.valid_out && bus.ready_in) begin
        n_tests++;
        if (q_exp.size() == 0) begin
          n_fail++; $display("FAIL beat: got unexpected beat %h expected none", got);
        end else begin
          e = q_exp.pop_front();
          if (got !== e) begin
            n_fail++; $display("FAIL beat: got last=%0b data=%0d expected last=%0b data=%0d", got[RW], got[RW-1:0], e[RW], e[RW-1:0]);
          end
        end
      end
      occ = occ + int'(h2) - int'(bus.valid_out && bus.ready_in);
      h2 = h1; h1 = bus.bram_en_out;
      prev_stall = bus.valid_out && !bus.ready_in;
      prev_beat  = got;
    end
  end

  task automatic do_start(input int base, input int len);
    @(posedge clk); #1;
    bus.start_in = 1'b1; bus.base_addr_in = 10'(base); bus.len_in = 11'(len); bus.ready_in = 1'b1;
    exp_addr = 10'(base);
    for (int i = 0; i < len; i++) q_exp.push_back({(i == len - 1), RW'((base + i) % RD)});
    @(posedge clk); #1;
    bus.start_in = 1'b0;
  endtask

  task automatic run_until_done(input int budget, input bit rnd, output int done_c, output int first_v,
                                output int last_c, output int beats, output int ens, output bit busy_d);
    done_c = -1; first_v = -1; last_c = -1; beats = 0; ens = 0; busy_d = 0;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (bus.valid_out && first_v < 0) first_v = k;
      if (bus.bram_en_out) ens++;
      if (bus.valid_out && bus.ready_in) begin beats++; if (bus.last_out) last_c = k; end
      if (bus.done_out) begin done_c = k; busy_d = bus.busy_out; break; end
      @(posedge clk); #1;
      if (rnd) bus.ready_in = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({bus.busy_out, bus.done_out, bus.bram_en_out, bus.valid_out, bus.last_out} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 00000", {bus.busy_out, bus.done_out, bus.bram_en_out, bus.valid_out, bus.last_out});
    end
    n_tests++;
    if (bus.bram_addr_out !== 10'd0 || bus.data_out !== 18'd0 || bus.bram_regce_out !== 1'b1) begin
      n_fail++; $display("FAIL reset_values: got addr=%0d data=%0d regce=%0b expected 0 0 1", bus.bram_addr_out, bus.data_out, bus.bram_regce_out);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int dc, fv, lc, nb, ne; bit bd;
    do_start(0, 8);
    run_until_done(40, 1'b0, dc, fv, lc, nb, ne, bd);
    n_tests++; if (fv !== 4)  begin n_fail++; $display("FAIL basic_first_valid: got cycle %0d expected 4", fv); end
    n_tests++; if (lc !== 11) begin n_fail++; $display("FAIL basic_last: got cycle %0d expected 11", lc); end
    n_tests++; if (dc !== 12) begin n_fail++; $display("FAIL basic_done: got cycle %0d expected 12", dc); end
    n_tests++; if (nb !== 8 || ne !== 8) begin n_fail++; $display("FAIL basic_counts: got beats=%0d reads=%0d expected 8 8", nb, ne); end
    n_tests++; if (bd !== 1'b1) begin n_fail++; $display("FAIL basic_busy_at_done: got %0b expected 1", bd); end
    @(negedge clk);
    n_tests++; if (bus.busy_out !== 1'b0) begin n_fail++; $display("FAIL basic_busy_drop: got %0b expected 0", bus.busy_out); end
  endtask

  task automatic test_wrap();
    int dc, fv, lc, nb, ne; bit bd;
    do_start(1020, 8);
    run_until_done(40, 1'b0, dc, fv, lc, nb, ne, bd);
    n_tests++; if (dc !== 12 || nb !== 8) begin n_fail++; $display("FAIL wrap: got done=%0d beats=%0d expected 12 8", dc, nb); end
    n_tests++; if (q_exp.size() !== 0) begin n_fail++; $display("FAIL wrap_drain: got %0d beats left expected 0", q_exp.size()); end
  endtask

  task automatic test_backpressure();
    int dc, fv, lc, nb, ne; bit bd;
    do_start(300, 16);
    run_until_done(300, 1'b1, dc, fv, lc, nb, ne, bd);
    n_tests++; if (dc < 0) begin n_fail++; $display("FAIL bp_timeout: got no done expected done within 300 cycles"); end
    n_tests++; if (nb !== 16 || ne !== 16) begin n_fail++; $display("FAIL bp_counts: got beats=%0d reads=%0d expected 16 16", nb, ne); end
    n_tests++; if (q_exp.size() !== 0) begin n_fail++; $display("FAIL bp_drain: got %0d beats left expected 0", q_exp.size()); end
  endtask

  task automatic test_zero_len();
    int dc, fv, lc, nb, ne; bit bd;
    do_start(7, 0);
    run_until_done(20, 1'b0, dc, fv, lc, nb, ne, bd);
    n_tests++; if (dc !== 2) begin n_fail++; $display("FAIL zero_done: got cycle %0d expected 2", dc); end
    n_tests++; if (ne !== 0 || fv !== -1) begin n_fail++; $display("FAIL zero_activity: got reads=%0d first_valid=%0d expected 0 -1", ne, fv); end
  endtask

  task automatic test_restart_ignored();
    int nb, ne, dc; bit bz;
    nb = 0; ne = 0; dc = -1; bz = 0;
    do_start(100, 12);
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (bus.bram_en_out) ne++;
      if (bus.valid_out && bus.ready_in) nb++;
      if (k == 6) bz = bus.busy_out;
      if (bus.done_out) begin dc = k; break; end
      @(posedge clk); #1;
      bus.start_in = (k == 5);
      if (k == 5) begin bus.base_addr_in = 10'd500; bus.len_in = 11'd3; end
    end
    n_tests++; if (bz !== 1'b1) begin n_fail++; $display("FAIL restart_busy: got %0b expected 1", bz); end
    n_tests++; if (nb !== 12 || ne !== 12 || dc !== 16) begin n_fail++; $display("FAIL restart_stream: got beats=%0d reads=%0d done=%0d expected 12 12 16", nb, ne, dc); end
  endtask

  task automatic test_full_wrap();
    int dc, fv, lc, nb, ne; bit bd;
    do_start(5, RD);
    run_until_done(1200, 1'b0, dc, fv, lc, nb, ne, bd);
    n_tests++; if (nb !== RD || ne !== RD || dc !== 1028) begin n_fail++; $display("FAIL full_wrap: got beats=%0d reads=%0d done=%0d expected 1024 1024 1028", nb, ne, dc); end
    n_tests++; if (q_exp.size() !== 0) begin n_fail++; $display("FAIL full_wrap_drain: got %0d beats left expected 0", q_exp.size()); end
  endtask

  task automatic test_reset_mid();
    int dc, fv, lc, nb, ne; bit bd;
    nb = 0;
    do_start(40, 10);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.valid_out && bus.ready_in) nb++;
      if (nb == 3) break;
      @(posedge clk); #1;
    end
    n_tests++; if (nb !== 3) begin n_fail++; $display("FAIL midrst_reach: got beats=%0d expected 3", nb); end
    @(posedge clk); #1;
    rst = 1'b1;
    q_exp.delete();
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({bus.busy_out, bus.done_out, bus.bram_en_out, bus.valid_out, bus.last_out} !== 5'b0 ||
        bus.bram_addr_out !== 10'd0 || bus.data_out !== 18'd0) begin
      n_fail++; $display("FAIL midrst_outputs: got flags=%b addr=%0d data=%0d expected 00000 0 0",
        {bus.busy_out, bus.done_out, bus.bram_en_out, bus.valid_out, bus.last_out}, bus.bram_addr_out, bus.data_out);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    do_start(0, 2);
    run_until_done(40, 1'b0, dc, fv, lc, nb, ne, bd);
    n_tests++; if (dc !== 6 || nb !== 2 || fv !== 4) begin n_fail++; $display("FAIL midrst_restart: got done=%0d beats=%0d first=%0d expected 6 2 4", dc, nb, fv); end
    n_tests++; if (q_exp.size() !== 0) begin n_fail++; $display("FAIL midrst_drain: got %0d beats left expected 0", q_exp.size()); end
  endtask

  initial begin
    rst = 1'b1;
    bus.start_in = 1'b0; bus.base_addr_in = '0; bus.len_in = '0; bus.ready_in = 1'b1;
    exp_addr = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_len();
    test_restart_ignored();
    test_full_wrap();
    test_reset_mid();
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
